// File: rtl/regfile_pkg.sv
// Shared definitions for param_regfile.
// Holds default widths, a packed-slice extractor and the popcount used for pend_count.
package regfile_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 5;

   // Helper capacity: up to 4 read ports of up to 16-bit addresses, up to 256 registers.
   localparam int SLICE_VEC_W = 64;
   localparam int SLICE_IDX_W = 6;
   localparam int SLICE_OUT_W = 16;
   localparam int POP_MAX_W   = 256;
   localparam int POP_OUT_W   = 16;

   function automatic logic [SLICE_OUT_W-1:0] get_slice(
      input logic [SLICE_VEC_W-1:0] vec,
      input int                     idx,
      input int                     w
   );
      logic [SLICE_OUT_W-1:0] res;
      res = {SLICE_OUT_W{1'b0}};
      for (int b = 0; b < SLICE_OUT_W; b++) begin
         if ((b < w) && ((idx * w + b) < SLICE_VEC_W)) begin
            res[b] = vec[SLICE_IDX_W'(idx * w + b)];
         end else begin
            res[b] = 1'b0;
         end
      end
      return res;
   endfunction

   function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_MAX_W-1:0] bits);
      logic [POP_OUT_W-1:0] cnt;
      cnt = {POP_OUT_W{1'b0}};
      for (int i = 0; i < POP_MAX_W; i++) begin
         cnt = cnt + {{(POP_OUT_W-1){1'b0}}, bits[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for hazard detection, with set-over-clear priority
// and a registered population count of outstanding writes.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    we0,
   input  logic [ADDR_W-1:0]       waddr0,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       waddr1,
   input  logic                    issue_valid,
   input  logic [ADDR_W-1:0]       issue_rd,
   output logic [(2**ADDR_W)-1:0]  pending,
   output logic [ADDR_W:0]         pend_count
);

   localparam int DEPTH   = 2**ADDR_W;
   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DEPTH-1:0]     pending_r;
   logic [DEPTH-1:0]     pending_next_s;
   logic [ADDR_W:0]      pend_count_r;
   logic [ADDR_W:0]      count_next_s;
   logic [POP_MAX_W-1:0] pend_wide_s;

   // Next pending state: a new issue outranks a completing write on the same register.
   always_comb begin
      pending_next_s = pending_r;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_valid && (issue_rd == ADDR_W'(i))) begin
            pending_next_s[i] = 1'b1;
         end else if ((we0 && (waddr0 == ADDR_W'(i))) || (we1 && (waddr1 == ADDR_W'(i)))) begin
            pending_next_s[i] = 1'b0;
         end else begin
            pending_next_s[i] = pending_r[i];
         end
      end
      pending_next_s[0] = ZERO_EN ? 1'b0 : pending_next_s[0];
      pend_wide_s = {POP_MAX_W{1'b0}};
      pend_wide_s[DEPTH-1:0] = pending_next_s;
      count_next_s = (ADDR_W+1)'(popcount(pend_wide_s));
   end

   // Pending bits and their count update together so the count never lags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_r    <= {DEPTH{1'b0}};
         pend_count_r <= {(ADDR_W+1){1'b0}};
      end else begin
         pending_r    <= pending_next_s;
         pend_count_r <= count_next_s;
      end
   end

   assign pending    = pending_r;
   assign pend_count = pend_count_r;

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file: NUM_RD combinational read ports, two write ports (port 1 wins),
// pending scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module param_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          waddr0,
   input  logic [DATA_W-1:0]          wdata0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          waddr1,
   input  logic [DATA_W-1:0]          wdata1,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic [NUM_RD-1:0]          rpend,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_rd,
   output logic [ADDR_W:0]            pend_count
);

   localparam int DEPTH   = 2**ADDR_W;
   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DATA_W-1:0]      mem_r [DEPTH];
   logic [DEPTH-1:0]       pending_s;
   logic                   wen0_s;
   logic                   wen1_s;
   logic [SLICE_VEC_W-1:0] raddr_wide_s;

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock       (clock),
      .reset       (reset),
      .we0         (we0),
      .waddr0      (waddr0),
      .we1         (we1),
      .waddr1      (waddr1),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .pending     (pending_s),
      .pend_count  (pend_count)
   );

   // Write arbitration: port 1 suppresses port 0 on a shared address; register 0 is read-only.
   always_comb begin
      wen1_s = we1 && !(ZERO_EN && (waddr1 == {ADDR_W{1'b0}}));
      wen0_s = we0 && !(ZERO_EN && (waddr0 == {ADDR_W{1'b0}}))
                   && !(we1 && (waddr1 == waddr0));
   end

   // Storage array; reset clears every entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (wen0_s) begin
            mem_r[waddr0] <= wdata0;
         end
         if (wen1_s) begin
            mem_r[waddr1] <= wdata1;
         end
      end
   end

   // Read muxes with optional write forwarding; register 0 overrides everything.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      logic              rp;
      raddr_wide_s = {SLICE_VEC_W{1'b0}};
      raddr_wide_s[NUM_RD*ADDR_W-1:0] = raddr;
      rdata = {(NUM_RD*DATA_W){1'b0}};
      rpend = {NUM_RD{1'b0}};
      for (int k = 0; k < NUM_RD; k++) begin
         ra = ADDR_W'(get_slice(raddr_wide_s, k, ADDR_W));
`ifdef REGFILE_BYPASS_EN
         if (!reset && we1 && (waddr1 == ra)) begin
            rd = wdata1;
            rp = issue_valid && (issue_rd == ra);
         end else if (!reset && we0 && (waddr0 == ra)) begin
            rd = wdata0;
            rp = issue_valid && (issue_rd == ra);
         end else begin
            rd = mem_r[ra];
            rp = pending_s[ra];
         end
`else
         rd = mem_r[ra];
         rp = pending_s[ra];
`endif
         rdata[k*DATA_W +: DATA_W] = (ZERO_EN && (ra == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : rd;
         rpend[k] = (ZERO_EN && (ra == {ADDR_W{1'b0}})) ? 1'b0 : rp;
      end
   end

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: a behavioural model predicts read results,
// which are queued on drive and popped when the outputs are sampled.
module tb_param_regfile;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int DEPTH  = 32;

   logic                     clock = 1'b0;
   logic                     reset;
   logic                     we0, we1, issue_valid;
   logic [ADDR_W-1:0]        waddr0, waddr1, issue_rd;
   logic [DATA_W-1:0]        wdata0, wdata1;
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rpend;
   logic [ADDR_W:0]          pend_count;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              pend;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] m_mem  [DEPTH];
   logic              m_pend [DEPTH];
   int                checks   = 0;
   int                failures = 0;

   param_regfile dut (
      .clock       (clock),
      .reset       (reset),
      .we0         (we0),
      .waddr0      (waddr0),
      .wdata0      (wdata0),
      .we1         (we1),
      .waddr1      (waddr1),
      .wdata1      (wdata1),
      .raddr       (raddr),
      .rdata       (rdata),
      .rpend       (rpend),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .pend_count  (pend_count)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t exp_read(input logic [ADDR_W-1:0] a);
      exp_t e;
      e.data = m_mem[a];
      e.pend = m_pend[a];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (waddr1 == a)) begin
         e.data = wdata1;
         e.pend = issue_valid && (issue_rd == a);
      end else if (we0 && (waddr0 == a)) begin
         e.data = wdata0;
         e.pend = issue_valid && (issue_rd == a);
      end
`endif
      if (a == 5'd0) begin
         e.data = 32'd0;
         e.pend = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [ADDR_W:0] model_count();
      logic [ADDR_W:0] c;
      c = 6'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_pend[i]) c = c + 6'd1;
      end
      return c;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = 32'd0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic model_update();
      if (we0 && (waddr0 != 5'd0)) m_mem[waddr0] = wdata0;
      if (we1 && (waddr1 != 5'd0)) m_mem[waddr1] = wdata1;
      if (we0) m_pend[waddr0] = 1'b0;
      if (we1) m_pend[waddr1] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0)) m_pend[issue_rd] = 1'b1;
   endtask

   task automatic check_reads(input string tag);
      exp_t e;
      for (int k = 0; k < NUM_RD; k++) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_q: expected-value queue empty", tag);
         end else begin
            e = exp_q.pop_front();
            check_val($sformatf("%s_rdata%0d", tag, k), 64'(rdata[k*DATA_W +: DATA_W]), 64'(e.data));
            check_val($sformatf("%s_rpend%0d", tag, k), 64'(rpend[k]), 64'(e.pend));
         end
      end
   endtask

   task automatic set_inputs(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                             input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                             input logic iv, input logic [4:0] ir,
                             input logic [4:0] r0, input logic [4:0] r1);
      we0 = w0; waddr0 = a0; wdata0 = d0;
      we1 = w1; waddr1 = a1; wdata1 = d1;
      issue_valid = iv; issue_rd = ir;
      raddr = {r1, r0};
   endtask

   task automatic drive(input string tag,
                        input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic iv, input logic [4:0] ir,
                        input logic [4:0] r0, input logic [4:0] r1);
      @(negedge clock);
      set_inputs(w0, a0, d0, w1, a1, d1, iv, ir, r0, r1);
      exp_q.push_back(exp_read(r0));
      exp_q.push_back(exp_read(r1));
      #1;
      check_reads(tag);
      @(posedge clock);
      #1;
      model_update();
      check_val({tag, "_cnt"}, 64'(pend_count), 64'(model_count()));
   endtask

   task automatic rd(input string tag, input logic [4:0] r0, input logic [4:0] r1);
      drive(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r0, r1);
   endtask

   initial begin
      exp_t z;
      z.data = 32'd0;
      z.pend = 1'b0;
      model_clear();
      reset = 1'b1;
      set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2);
      #12;
      exp_q.push_back(exp_read(5'd1));
      exp_q.push_back(exp_read(5'd2));
      check_reads("reset");
      check_val("reset_cnt", 64'(pend_count), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      drive("wr11", 1'b1, 5'd11, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2);
      drive("wr22", 1'b1, 5'd22, 32'hEEEE, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd2);
      rd("rd11_22", 5'd11, 5'd22);

      drive("both7", 1'b1, 5'd7, 32'h1111, 1'b1, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd11, 5'd22);
      drive("wr0a", 1'b1, 5'd0, 32'hABCD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd11);
      drive("wr0b", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hABCD, 1'b0, 5'd0, 5'd7, 5'd22);
      rd("rd7_0", 5'd7, 5'd0);

      drive("iss5", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6, 5'd7);
      rd("pend5", 5'd5, 5'd4);
      drive("setclr5", 1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6, 5'd7);
      rd("still5", 5'd5, 5'd7);
      drive("clr5", 1'b1, 5'd5, 32'h5A5A, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd7);
      rd("clear5", 5'd5, 5'd11);

      for (int i = 1; i < 32; i++) begin
         drive($sformatf("iss%0d", i), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
               1'b1, 5'(i), 5'(i), 5'(i - 1));
      end
      drive("iss0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd31);
      check_val("full_cnt", 64'(pend_count), 64'd31);
      for (int i = 1; i < 32; i += 2) begin
         drive($sformatf("clr%0d", i), 1'b1, 5'(i), $urandom, 1'b1, 5'(i + 1), $urandom,
               1'b0, 5'd0, 5'(i), 5'(i + 2));
      end
      rd("drained", 5'd9, 5'd30);

      drive("pre3", 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd5);
      drive("byp3", 1'b1, 5'd3, 32'h55AA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);
      drive("byp3i", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA5A5, 1'b1, 5'd3, 5'd3, 5'd3);
      rd("post3", 5'd3, 5'd4);

      for (int n = 0; n < 60; n++) begin
         drive($sformatf("rnd%0d", n), 1'($urandom), 5'($urandom), $urandom,
               1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom));
      end

      drive("pre9", 1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd9, 5'd12);
      @(negedge clock);
      set_inputs(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd9, 5'd12);
      #1;
      reset = 1'b1;
      #1;
      exp_q.push_back(z);
      exp_q.push_back(z);
      check_reads("async_rst");
      check_val("async_rst_cnt", 64'(pend_count), 64'd0);
      @(posedge clock);
      #1;
      exp_q.push_back(z);
      exp_q.push_back(z);
      check_reads("held_rst");
      check_val("held_rst_cnt", 64'(pend_count), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd12);
      model_clear();
      rd("after_rst", 5'd9, 5'd12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the 32x32 two-read/one-write RegFile used by the pipeline ID/WB stages.
- Generalises data width, depth and read-port count, and adds a second write port with priority.
- Adds a per-register pending scoreboard, which hazard detection uses to stall on outstanding writes.
- Adds optional write-to-read bypass.
- Sits between the ID stage (reads, issue) and the WB stage (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all registers and the scoreboard
- we0  in  1  write-port-0 enable (WB stage)
- waddr0  in  ADDR_W  write-port-0 address
- wdata0  in  DATA_W  write-port-0 data
- we1  in  1  write-port-1 enable (load/debug path; higher priority)
- waddr1  in  ADDR_W  write-port-1 address
- wdata1  in  DATA_W  write-port-1 data
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port k uses slice [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  packed read data
- rpend  out  NUM_RD  1 = addressed register has an outstanding write
- issue_valid  in  1  set the pending bit for issue_rd
- issue_rd  in  ADDR_W  destination register being issued
- pend_count  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset:
  - All registers are 0 and all pending bits are 0 immediately on reset assertion; pend_count = 0.
  - rdata reflects the zero contents combinationally.
  - Reset mid-write or mid-issue aborts that update; nothing survives reset.
- Write:
  - Writes take effect on posedge clock when weN = 1.
  - When we0 and we1 target the same address, wdata1 is stored.
  - Writes to register 0 are discarded when ZERO_REG = 1.
- Read:
  - Reads are combinational from the array.
  - Read latency is 0 cycles after the address changes; written data is visible on the cycle after the write edge (no bypass case).
  - Register 0 reads as 0 when ZERO_REG = 1.
- Scoreboard:
  - One pending bit per register.
  - Set: issue_valid at posedge sets pending[issue_rd].
  - Clear: any enabled write port clears pending[waddrN] at the same edge.
  - Set and clear on the same register at the same edge: set wins (a newer producer is outstanding).
  - Issuing an already-pending register keeps it pending; there is no counting.
  - issue_rd = 0 with ZERO_REG = 1 is ignored.
  - rpend[k] = pending[raddr k] combinationally.
- pend_count:
  - Registered population count of the pending bits, updated on the same edge as the bits.
  - Range 0..2**ADDR_W; no wrap.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - If a read address matches an enabled write address in the same cycle, rdata returns that write data (wdata1 when both ports match).
  - rpend for that port reads 0 unless issue_valid targets the same register in the same cycle.
  - Zero-register rule still applies.
- REGFILE_BYPASS_EN undefined:
  - Reads return the array contents only; the pipeline forwarding unit covers the hazard.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W localparams
  - a function extracting a packed slice
  - the popcount function used for pend_count
- One sub-module, regfile_scoreboard, holds the pending bits, the set/clear priority and pend_count.
- The storage array, write arbitration and read muxes stay in the top level.

Test Plan:
- Reset, no writes, raddr = {1,2} -> rdata = 0, rpend = 0, pend_count = 0; assert reset mid-run after writes -> all zero asynchronously, before the next edge.
- we0 = 1, waddr0 = 11, wdata0 = 0xFFFF at edge; next cycle we0 = 1, waddr0 = 22, wdata0 = 0xEEEE; then read raddr = {11,22} -> rdata = {0xFFFF, 0xEEEE}.
- we0 and we1 both to register 7, with wdata0 = 0x1111 and wdata1 = 0x2222 -> register 7 reads 0x2222; write 0xABCD to register 0 -> reads 0.
- issue_valid, issue_rd = 5 -> rpend = 1 and pend_count = 1 next cycle; we0 to register 5 together with issue_valid to register 5 -> still pending; we0 to register 5 alone -> pending clears and pend_count = 0.
- Issue 31 distinct registers (1..31) -> pend_count = 31; issue register 0 -> pend_count stays 31.
- With REGFILE_BYPASS_EN: we0 to register 3 with 0x55AA and raddr = 3 in the same cycle -> rdata = 0x55AA before the edge. Without the macro -> old value until after the edge.
